riscv_mem_interconnect: RTL and testbench
=========================================

Name: riscv_mem_interconnect

Overview:
Parametrised successor to the fixed CPU-to-memory-controller hookup. It takes the CPU memory port (addr/wdata/rdata/wstrb/we/re/ready) and routes each access to one of NUM_SLAVES targets using a region decode on the upper address bits. Decode misses and slave timeouts return a bus-error response instead of hanging the CPU. The block captures the error address and keeps a saturating error count for the debug path. It sits between the CPU core and the memory controller and peripherals inside the virtual device top level.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
NUM_SLAVES, 4, number of slave ports (1..16)
REGION_W, 4, address MSBs used for decode (addr[ADDR_W-1 -: REGION_W])
SLAVE_BASE, {4'h3,4'h2,4'h1,4'h0}, packed NUM_SLAVES*REGION_W; slice i = region of slave i
TIMEOUT, 255, max cycles waiting for s_ready before abort (>=1)
ERR_DATA, 32'hDEAD_BEEF, rdata returned on error
ERR_CNT_W, 8, error counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
cpu_addr  in  ADDR_W  request address, held until cpu_ready
cpu_wdata  in  DATA_W  write data
cpu_wstrb  in  DATA_W/8  byte enables
cpu_we  in  1  write request
cpu_re  in  1  read request
cpu_rdata  out  DATA_W  read data, valid with cpu_ready
cpu_ready  out  1  one-cycle completion pulse
cpu_err  out  1  error flag, valid with cpu_ready
s_sel  out  NUM_SLAVES  one-hot slave select
s_addr  out  ADDR_W  registered address to slaves
s_wdata  out  DATA_W  registered write data
s_wstrb  out  DATA_W/8  registered strobes
s_we  out  1  write strobe, held until s_ready or abort
s_re  out  1  read strobe, held until s_ready or abort
s_rdata  in  NUM_SLAVES*DATA_W  packed slave read data
s_ready  in  NUM_SLAVES  per-slave completion
err_addr  out  ADDR_W  address of most recent error
err_count  out  ERR_CNT_W  saturating error count

Behaviour:
- Reset (rst=1 at a clock edge): FSM=IDLE. All outputs 0: cpu_rdata, cpu_ready, cpu_err, s_sel, s_addr, s_wdata, s_wstrb, s_we, s_re, err_addr, err_count. Timeout counter 0. Reset mid-transaction drops all strobes on that edge and discards the response.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If cpu_we|cpu_re, decode region = cpu_addr[ADDR_W-1 -: REGION_W] against each SLAVE_BASE slice. The lowest-index match wins.
  - Hit: register addr/wdata/wstrb. Set s_sel one-hot. Set s_we=cpu_we. Set s_re=cpu_re & ~cpu_we (write wins if both asserted). Go to ACCESS with timer=0.
  - Miss: go to RESP with err=1 and rdata=ERR_DATA. No slave strobe is issued.
- ACCESS:
  - s_ready is qualified by s_sel; s_ready bits of unselected slaves are ignored.
  - On selected s_ready: clear s_sel/s_we/s_re. Register selected s_rdata slice (reads only; writes return 0). Set err=0. Go to RESP.
  - Else increment timer. When timer==TIMEOUT-1 with no ready: clear strobes, err=1, rdata=ERR_DATA, go to RESP.
- RESP: cpu_ready=1, with cpu_rdata/cpu_err, for exactly one cycle. Then go to IDLE. cpu_ready is 0 in all other states.
- Latency:
  - Miss: cpu_ready 2 cycles after request is sampled.
  - Hit with s_ready in the first ACCESS cycle: cpu_ready 3 cycles after request.
  - Each extra slave wait cycle adds 1.
  - Requests still asserted in the cycle after RESP start a new access (back-to-back allowed, no bubble beyond IDLE).
- Errors: on entry to RESP with err=1, err_addr <= request address. err_count increments and saturates at 2^ERR_CNT_W-1 (no wrap).
- A late s_ready after abort is ignored (s_sel already 0).
- cpu_* request inputs are not sampled outside IDLE.

Test Plan:
- Read hit: NUM_SLAVES=4, cpu_re with addr 32'h2000_0010; slave2 s_ready in first ACCESS cycle with s_rdata slice 32'h1234_5678 -> s_sel=4'b0100, s_re=1 for one cycle; cpu_ready 3 cycles after request with cpu_rdata=32'h1234_5678, cpu_err=0.
- Write with wait states: cpu_we with addr 32'h1000_0004, wdata 32'hCAFE_0001, wstrb 4'b0011; slave1 s_ready after 5 cycles -> s_wdata/s_wstrb held stable for all 5 cycles; cpu_ready at cycle 8, cpu_err=0.
- Decode miss: read of 32'h9000_0000 -> no s_sel bit ever set; cpu_ready at cycle 2 with cpu_rdata=32'hDEAD_BEEF, cpu_err=1, err_addr=32'h9000_0000, err_count=1.
- Timeout and saturation: TIMEOUT=4, ERR_CNT_W=2, slave0 never ready; issue 5 reads to 32'h0000_0000 -> each access aborts after 4 ACCESS cycles with cpu_err=1; err_count goes 1,2,3,3,3.
- Simultaneous we+re plus stray ready: both asserted to slave3 -> s_we=1, s_re=0. s_ready[0] asserted while slave3 selected -> ignored; completion occurs only on s_ready[3].
- Reset mid-access: assert rst during ACCESS -> next edge all strobes and outputs 0, FSM IDLE, no cpu_ready pulse. err_count is also reset to 0.

Source files
------------

// File: rtl/riscv_mem_interconnect_if.sv
// rtl/riscv_mem_interconnect_if.sv - CPU-side and slave-side bus bundle for riscv_mem_interconnect
//
// CPU side : cpu_addr/cpu_wdata/cpu_wstrb/cpu_we/cpu_re requests in,
//            cpu_rdata/cpu_ready/cpu_err response out.
// Slave side: s_sel (one-hot), s_addr/s_wdata/s_wstrb/s_we/s_re out,
//            s_rdata (packed per slave) and s_ready (per slave) in.
// Modport master: the requesting CPU plus the slave models (drives requests and slave responses).
// Modport slave : the interconnect itself.
interface riscv_mem_interconnect_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4
);
  logic [ADDR_W-1:0]            cpu_addr;
  logic [DATA_W-1:0]            cpu_wdata;
  logic [DATA_W/8-1:0]          cpu_wstrb;
  logic                         cpu_we;
  logic                         cpu_re;
  logic [DATA_W-1:0]            cpu_rdata;
  logic                         cpu_ready;
  logic                         cpu_err;

  logic [NUM_SLAVES-1:0]        s_sel;
  logic [ADDR_W-1:0]            s_addr;
  logic [DATA_W-1:0]            s_wdata;
  logic [DATA_W/8-1:0]          s_wstrb;
  logic                         s_we;
  logic                         s_re;
  logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
  logic [NUM_SLAVES-1:0]        s_ready;

  modport master (
    output cpu_addr, cpu_wdata, cpu_wstrb, cpu_we, cpu_re,
    input  cpu_rdata, cpu_ready, cpu_err,
    input  s_sel, s_addr, s_wdata, s_wstrb, s_we, s_re,
    output s_rdata, s_ready
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_wstrb, cpu_we, cpu_re,
    output cpu_rdata, cpu_ready, cpu_err,
    output s_sel, s_addr, s_wdata, s_wstrb, s_we, s_re,
    input  s_rdata, s_ready
  );
endinterface

// File: rtl/riscv_mem_interconnect.sv
// rtl/riscv_mem_interconnect.sv - region-decoded CPU to NUM_SLAVES router with timeout and bus-error reporting
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous reset, active-high
//   bus       - riscv_mem_interconnect_if.slave (CPU request/response + slave strobes/responses)
//   err_addr  - address of the most recent errored access
//   err_count - saturating count of errored accesses
module riscv_mem_interconnect #(
  parameter int                              ADDR_W     = 32,
  parameter int                              DATA_W     = 32,
  parameter int                              NUM_SLAVES = 4,
  parameter int                              REGION_W   = 4,
  parameter logic [NUM_SLAVES*REGION_W-1:0]  SLAVE_BASE = {4'h3, 4'h2, 4'h1, 4'h0},
  parameter int                              TIMEOUT    = 255,
  parameter logic [DATA_W-1:0]               ERR_DATA   = 32'hDEAD_BEEF,
  parameter int                              ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  riscv_mem_interconnect_if.slave bus,
  output logic [ADDR_W-1:0]     err_addr,
  output logic [ERR_CNT_W-1:0]  err_count
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                 state_q,     state_d;
  logic [TMR_W-1:0]       timer_q,     timer_d;
  logic [DATA_W-1:0]      cpu_rdata_q, cpu_rdata_d;
  logic                   cpu_ready_q, cpu_ready_d;
  logic                   cpu_err_q,   cpu_err_d;
  logic [NUM_SLAVES-1:0]  s_sel_q,     s_sel_d;
  logic [ADDR_W-1:0]      s_addr_q,    s_addr_d;
  logic [DATA_W-1:0]      s_wdata_q,   s_wdata_d;
  logic [DATA_W/8-1:0]    s_wstrb_q,   s_wstrb_d;
  logic                   s_we_q,      s_we_d;
  logic                   s_re_q,      s_re_d;
  logic [ADDR_W-1:0]      err_addr_q,  err_addr_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

  logic [REGION_W-1:0]    region;
  logic [NUM_SLAVES-1:0]  dec_sel;
  logic                   sel_ready;
  logic [DATA_W-1:0]      sel_rdata;
  logic [ERR_CNT_W-1:0]   err_count_inc;

  assign region        = bus.cpu_addr[ADDR_W-1 -: REGION_W];
  // Unselected slaves cannot complete the access, including a late ready after abort.
  assign sel_ready     = |(bus.s_ready & s_sel_q);
  assign err_count_inc = (&err_count_q) ? err_count_q : err_count_q + ERR_CNT_W'(1);

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    dec_sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (region == SLAVE_BASE[i*REGION_W +: REGION_W]) begin
        dec_sel    = '0;
        dec_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (s_sel_q[i]) sel_rdata = sel_rdata | bus.s_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ready_d = 1'b0;
    cpu_err_d   = cpu_err_q;
    s_sel_d     = s_sel_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    s_wstrb_d   = s_wstrb_q;
    s_we_d      = s_we_q;
    s_re_d      = s_re_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (bus.cpu_we || bus.cpu_re) begin
          if (|dec_sel) begin
            s_sel_d   = dec_sel;
            s_addr_d  = bus.cpu_addr;
            s_wdata_d = bus.cpu_wdata;
            s_wstrb_d = bus.cpu_wstrb;
            s_we_d    = bus.cpu_we;
            s_re_d    = bus.cpu_re & ~bus.cpu_we;
            state_d   = ACCESS;
          end else begin
            cpu_ready_d = 1'b1;
            cpu_err_d   = 1'b1;
            cpu_rdata_d = ERR_DATA;
            err_addr_d  = bus.cpu_addr;
            err_count_d = err_count_inc;
            state_d     = RESP;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          cpu_ready_d = 1'b1;
          cpu_err_d   = 1'b0;
          cpu_rdata_d = s_re_q ? sel_rdata : '0;
          s_sel_d     = '0;
          s_we_d      = 1'b0;
          s_re_d      = 1'b0;
          state_d     = RESP;
        end else if (timer_q == TMR_LAST) begin
          cpu_ready_d = 1'b1;
          cpu_err_d   = 1'b1;
          cpu_rdata_d = ERR_DATA;
          err_addr_d  = s_addr_q;
          err_count_d = err_count_inc;
          s_sel_d     = '0;
          s_we_d      = 1'b0;
          s_re_d      = 1'b0;
          state_d     = RESP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_err_q   <= 1'b0;
      s_sel_q     <= '0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_wstrb_q   <= '0;
      s_we_q      <= 1'b0;
      s_re_q      <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_err_q   <= cpu_err_d;
      s_sel_q     <= s_sel_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_wstrb_q   <= s_wstrb_d;
      s_we_q      <= s_we_d;
      s_re_q      <= s_re_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.cpu_err   = cpu_err_q;
  assign bus.s_sel     = s_sel_q;
  assign bus.s_addr    = s_addr_q;
  assign bus.s_wdata   = s_wdata_q;
  assign bus.s_wstrb   = s_wstrb_q;
  assign bus.s_we      = s_we_q;
  assign bus.s_re      = s_re_q;
  assign err_addr      = err_addr_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_riscv_mem_interconnect.sv
// tb/tb_riscv_mem_interconnect.sv - directed self-checking bench for riscv_mem_interconnect
module tb_riscv_mem_interconnect;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: default parameters.
  riscv_mem_interconnect_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4)) bus_a ();
  logic [31:0] err_addr_a;
  logic [7:0]  err_count_a;

  riscv_mem_interconnect #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4), .REGION_W(4),
    .SLAVE_BASE({4'h3, 4'h2, 4'h1, 4'h0}), .TIMEOUT(255),
    .ERR_DATA(32'hDEAD_BEEF), .ERR_CNT_W(8)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .err_addr(err_addr_a), .err_count(err_count_a)
  );

  // Instance B: short timeout and narrow error counter for abort/saturation.
  riscv_mem_interconnect_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4)) bus_b ();
  logic [31:0] err_addr_b;
  logic [1:0]  err_count_b;

  riscv_mem_interconnect #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4), .REGION_W(4),
    .SLAVE_BASE({4'h3, 4'h2, 4'h1, 4'h0}), .TIMEOUT(4),
    .ERR_DATA(32'hDEAD_BEEF), .ERR_CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .err_addr(err_addr_b), .err_count(err_count_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit got;

    bus_a.cpu_addr = '0; bus_a.cpu_wdata = '0; bus_a.cpu_wstrb = '0;
    bus_a.cpu_we = 1'b0; bus_a.cpu_re = 1'b0;
    bus_a.s_rdata = {32'h3333_3333, 32'h1234_5678, 32'h1111_1111, 32'h0BAD_0000};
    bus_a.s_ready = '0;
    bus_b.cpu_addr = '0; bus_b.cpu_wdata = '0; bus_b.cpu_wstrb = '0;
    bus_b.cpu_we = 1'b0; bus_b.cpu_re = 1'b0;
    bus_b.s_rdata = '0; bus_b.s_ready = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", bus_a.cpu_ready, 1'b0);
    check("rst_rdata", bus_a.cpu_rdata, 32'h0);
    check("rst_sel",   bus_a.s_sel, 4'b0000);
    check("rst_we_re", {bus_a.s_we, bus_a.s_re}, 2'b00);
    check("rst_addr",  bus_a.s_addr, 32'h0);
    check("rst_cnt",   err_count_a, 8'd0);
    rst = 1'b0;

    // Read hit to slave 2, ready in first ACCESS cycle; request cycle = cycle 1
    @(negedge clk);
    bus_a.cpu_addr = 32'h2000_0010; bus_a.cpu_re = 1'b1;
    @(negedge clk);  // cycle 2: ACCESS
    check("rh_sel",   bus_a.s_sel, 4'b0100);
    check("rh_re",    bus_a.s_re, 1'b1);
    check("rh_we",    bus_a.s_we, 1'b0);
    check("rh_saddr", bus_a.s_addr, 32'h2000_0010);
    check("rh_early", bus_a.cpu_ready, 1'b0);
    bus_a.s_ready = 4'b0100;
    @(negedge clk);  // cycle 3: RESP
    bus_a.s_ready = 4'b0000;
    check("rh_ready", bus_a.cpu_ready, 1'b1);
    check("rh_rdata", bus_a.cpu_rdata, 32'h1234_5678);
    check("rh_err",   bus_a.cpu_err, 1'b0);
    check("rh_clr",   {bus_a.s_sel, bus_a.s_re}, 5'b0);
    bus_a.cpu_re = 1'b0;
    @(negedge clk);
    check("rh_pulse", bus_a.cpu_ready, 1'b0);

    // Write to slave 1 with five wait cycles
    bus_a.cpu_addr = 32'h1000_0004; bus_a.cpu_wdata = 32'hCAFE_0001;
    bus_a.cpu_wstrb = 4'b0011; bus_a.cpu_we = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);  // cycles 2..7: ACCESS
      check("wr_wdata", bus_a.s_wdata, 32'hCAFE_0001);
      check("wr_wstrb", bus_a.s_wstrb, 4'b0011);
      check("wr_we",    {bus_a.s_sel, bus_a.s_we, bus_a.s_re}, 6'b0010_10);
      check("wr_wait",  bus_a.cpu_ready, 1'b0);
      bus_a.cpu_wdata = 32'h5555_5555;  // request is not resampled outside IDLE
    end
    bus_a.s_ready = 4'b0010;
    @(negedge clk);  // cycle 8: RESP
    bus_a.s_ready = 4'b0000;
    check("wr_ready", bus_a.cpu_ready, 1'b1);
    check("wr_err",   bus_a.cpu_err, 1'b0);
    check("wr_rdata", bus_a.cpu_rdata, 32'h0);
    bus_a.cpu_we = 1'b0;
    @(negedge clk);

    // Decode miss
    bus_a.cpu_addr = 32'h9000_0000; bus_a.cpu_re = 1'b1;
    @(negedge clk);  // cycle 2: RESP
    check("ms_ready", bus_a.cpu_ready, 1'b1);
    check("ms_rdata", bus_a.cpu_rdata, 32'hDEAD_BEEF);
    check("ms_err",   bus_a.cpu_err, 1'b1);
    check("ms_sel",   {bus_a.s_sel, bus_a.s_re, bus_a.s_we}, 6'b0);
    check("ms_eaddr", err_addr_a, 32'h9000_0000);
    check("ms_ecnt",  err_count_a, 8'd1);
    bus_a.cpu_re = 1'b0;
    @(negedge clk);
    check("ms_sel2",  bus_a.s_sel, 4'b0000);

    // we+re together to slave 3, stray ready from slave 0
    bus_a.cpu_addr = 32'h3000_0008; bus_a.cpu_wdata = 32'h0000_00AA;
    bus_a.cpu_wstrb = 4'b1111; bus_a.cpu_we = 1'b1; bus_a.cpu_re = 1'b1;
    @(negedge clk);  // cycle 2: ACCESS
    check("wr_both_sel", bus_a.s_sel, 4'b1000);
    check("wr_both_we",  {bus_a.s_we, bus_a.s_re}, 2'b10);
    bus_a.s_ready = 4'b0001;
    @(negedge clk);  // cycle 3: still ACCESS
    check("stray_ready", bus_a.cpu_ready, 1'b0);
    check("stray_sel",   bus_a.s_sel, 4'b1000);
    bus_a.s_ready = 4'b1000;
    @(negedge clk);  // cycle 4: RESP
    bus_a.s_ready = 4'b0000;
    check("both_ready", bus_a.cpu_ready, 1'b1);
    check("both_err",   bus_a.cpu_err, 1'b0);
    check("both_ecnt",  err_count_a, 8'd1);
    bus_a.cpu_we = 1'b0; bus_a.cpu_re = 1'b0;
    @(negedge clk);

    // Timeout and saturation on instance B: slave 0 never ready
    for (int i = 0; i < 5; i++) begin
      bus_b.cpu_addr = 32'h0000_0000; bus_b.cpu_re = 1'b1;
      n = 0; got = 1'b0;
      while (!got && n < 12) begin
        @(negedge clk);
        n++;
        if (bus_b.cpu_ready) got = 1'b1;
        else if (n == 2) check("to_re_held", {bus_b.s_sel, bus_b.s_re}, 5'b0001_1);
      end
      check("to_latency", n, 5);  // cycles 2..5 ACCESS, RESP at cycle 6
      check("to_err",     bus_b.cpu_err, 1'b1);
      check("to_rdata",   bus_b.cpu_rdata, 32'hDEAD_BEEF);
      check("to_strobes", {bus_b.s_sel, bus_b.s_re}, 5'b0);
      check("to_ecnt",    err_count_b, (i < 3) ? i + 1 : 3);
      bus_b.cpu_re = 1'b0;
      @(negedge clk);
    end

    // Reset during ACCESS
    bus_a.cpu_addr = 32'h0000_0100; bus_a.cpu_re = 1'b1;
    @(negedge clk);  // ACCESS
    check("rm_re", bus_a.s_re, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rm_sel",   bus_a.s_sel, 4'b0000);
    check("rm_we_re", {bus_a.s_we, bus_a.s_re}, 2'b00);
    check("rm_addr",  bus_a.s_addr, 32'h0);
    check("rm_ready", bus_a.cpu_ready, 1'b0);
    check("rm_ecnt",  err_count_a, 8'd0);
    check("rm_eaddr", err_addr_a, 32'h0);
    check("rm_ecntb", err_count_b, 2'd0);
    bus_a.cpu_re = 1'b0;
    rst = 1'b0;
    bus_a.s_ready = 4'b0001;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus_a.cpu_ready) n++;
    end
    bus_a.s_ready = 4'b0000;
    check("rm_no_resp", n, 0);
    check("rm_idle_sel", bus_a.s_sel, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
